// File: rtl/fixed_softmax_grad.sv
// Softmax backward pass: dx_i = y_i * (g_i - sum_j y_j*g_j), streamed in blocks of PARALLELISM lanes.
// Latency: the first dx beat is presented the cycle after the last input beat of a vector is accepted.
// Backpressure: single-buffered; input is stalled for the whole EMIT phase, output beats hold while data_out_ready is low.
// Optional build macro FIXED_SOFTMAX_GRAD_SAT_EN: saturate dx to OUT_WIDTH instead of wrapping.
module fixed_softmax_grad #(
    parameter int Y_WIDTH     = 8,
    parameter int Y_FRAC      = 7,
    parameter int G_WIDTH     = 8,
    parameter int G_FRAC      = 4,
    parameter int OUT_WIDTH   = 8,
    parameter int OUT_FRAC    = 4,
    parameter int TENSOR_SIZE = 4,
    parameter int PARALLELISM = 2,
    parameter int DEPTH       = TENSOR_SIZE / PARALLELISM
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [Y_WIDTH-1:0]   y_in [PARALLELISM],
    input  logic [G_WIDTH-1:0]   g_in [PARALLELISM],
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [OUT_WIDTH-1:0] data_out [PARALLELISM],
    output logic                 data_out_valid,
    input  logic                 data_out_ready
);

    // Product of unsigned y and signed g, with one guard bit for the sign of y.
    localparam int PW    = Y_WIDTH + G_WIDTH + 1;
    // Accumulator grows by log2 of the vector length so the dot product cannot overflow.
    localparam int ACC_W = PW + $clog2(TENSOR_SIZE);
    localparam int DW    = ACC_W + 1;
    localparam int FW    = Y_WIDTH + 1 + DW;
    localparam int SH    = 2 * Y_FRAC + G_FRAC - OUT_FRAC;
    localparam int RND_SH = (SH > 0) ? SH - 1 : 0;
    localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Half-LSB of the output format; zero when no bits are dropped.
    localparam logic signed [FW-1:0] RND = (SH > 0) ? (FW'(1) <<< RND_SH) : '0;

    typedef enum logic {ACCUM, EMIT} state_t;

    state_t state_q, state_d;

    logic [CW-1:0]           wcnt_q, wcnt_d;
    logic [CW-1:0]           rcnt_q, rcnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] s_q, s_d;

    logic [Y_WIDTH-1:0] y_buf_q [DEPTH][PARALLELISM];
    logic [G_WIDTH-1:0] g_buf_q [DEPTH][PARALLELISM];

    logic signed [PW-1:0]    prod     [PARALLELISM];
    logic signed [ACC_W-1:0] beat_sum;
    logic signed [DW-1:0]    g_sh     [PARALLELISM];
    logic signed [DW-1:0]    diff     [PARALLELISM];
    logic signed [FW-1:0]    full     [PARALLELISM];
    logic signed [FW-1:0]    rnd      [PARALLELISM];
    logic [OUT_WIDTH-1:0]    dx       [PARALLELISM];

    logic in_fire, out_fire, last_in, last_out;

    assign in_fire  = data_in_valid && data_in_ready;
    assign out_fire = data_out_valid && data_out_ready;
    assign last_in  = in_fire && (wcnt_q == CW'(DEPTH - 1));
    assign last_out = out_fire && (rcnt_q == CW'(DEPTH - 1));

    // State register: reset always returns to ACCUM, discarding any partial vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: switch to EMIT on the last input beat, back to ACCUM on the last output beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (last_in)  state_d = EMIT;
            EMIT:    if (last_out) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Outputs: handshakes depend only on state; data is forced to zero when not valid.
    always_comb begin
        data_in_ready  = (state_q == ACCUM);
        data_out_valid = (state_q == EMIT);
        for (int k = 0; k < PARALLELISM; k++) begin
            data_out[k] = data_out_valid ? dx[k] : '0;
        end
    end

    // Per-beat dot product contribution sum_k y_k*g_k in the accumulator width.
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < PARALLELISM; k++) begin
            prod[k]  = $signed(PW'({1'b0, y_in[k]})) * PW'($signed(g_in[k]));
            beat_sum = beat_sum + ACC_W'(prod[k]);
        end
    end

    // Counter and accumulator next-state; s captures the full dot product on the last input beat.
    always_comb begin
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        acc_d  = acc_q;
        s_d    = s_q;
        if (in_fire) begin
            if (last_in) begin
                wcnt_d = '0;
                s_d    = acc_q + beat_sum;
                acc_d  = '0;
            end else begin
                wcnt_d = wcnt_q + CW'(1);
                acc_d  = acc_q + beat_sum;
            end
        end
        if (out_fire) begin
            rcnt_d = last_out ? '0 : rcnt_q + CW'(1);
        end
    end

    // Control datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            rcnt_q <= '0;
            acc_q  <= '0;
            s_q    <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
            acc_q  <= acc_d;
            s_q    <= s_d;
        end
    end

    // Vector buffer: contents are only read in EMIT after a full vector has been written.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int k = 0; k < PARALLELISM; k++) begin
                y_buf_q[wcnt_q][k] <= y_in[k];
                g_buf_q[wcnt_q][k] <= g_in[k];
            end
        end
    end

`ifdef FIXED_SOFTMAX_GRAD_SAT_EN
    localparam logic signed [FW-1:0] OMAX = (FW'(1) <<< (OUT_WIDTH - 1)) - FW'(1);
    localparam logic signed [FW-1:0] OMIN = -OMAX - FW'(1);
`endif

    // dx per lane: align g to s, subtract, scale by y, round half up, then narrow.
    always_comb begin
        for (int k = 0; k < PARALLELISM; k++) begin
            g_sh[k] = DW'($signed(g_buf_q[rcnt_q][k])) <<< Y_FRAC;
            diff[k] = g_sh[k] - DW'(s_q);
            full[k] = $signed(FW'({1'b0, y_buf_q[rcnt_q][k]})) * FW'(diff[k]);
            rnd[k]  = (full[k] + RND) >>> SH;
`ifdef FIXED_SOFTMAX_GRAD_SAT_EN
            if (rnd[k] > OMAX) begin
                dx[k] = OUT_WIDTH'(OMAX);
            end else if (rnd[k] < OMIN) begin
                dx[k] = OUT_WIDTH'(OMIN);
            end else begin
                dx[k] = OUT_WIDTH'(rnd[k]);
            end
`else
            dx[k] = OUT_WIDTH'(rnd[k]);
`endif
        end
    end

endmodule

// File: tb/tb_fixed_softmax_grad.sv
// Self-checking bench for fixed_softmax_grad with default parameters.
// Expected dx beats come from an integer reference model and are queued when a vector is driven.
// Build with FIXED_SOFTMAX_GRAD_SAT_EN defined to check the saturating variant.
module tb_fixed_softmax_grad;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] y_in [2];
    logic [7:0] g_in [2];
    logic       data_in_valid;
    logic       data_in_ready;
    logic [7:0] data_out [2];
    logic       data_out_valid;
    logic       data_out_ready;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fixed_softmax_grad #(
        .Y_WIDTH(8), .Y_FRAC(7), .G_WIDTH(8), .G_FRAC(4),
        .OUT_WIDTH(8), .OUT_FRAC(4), .TENSOR_SIZE(4), .PARALLELISM(2), .DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .y_in(y_in),
        .g_in(g_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    // Reference: y has 7 fractional bits, g has 4, s has 11, full has 18, dx has 4 -> shift by 14.
    function automatic logic [31:0] model(input int yv[4], input int gv[4]);
        longint s, diff, full, r;
        longint gs[4];
        logic [31:0] res;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            gs[k] = (gv[k] >= 128) ? longint'(gv[k] - 256) : longint'(gv[k]);
            s = s + longint'(yv[k]) * gs[k];
        end
        for (int k = 0; k < 4; k++) begin
            diff = gs[k] * 128 - s;
            full = longint'(yv[k]) * diff;
            r = (full + 8192) >>> 14;
`ifdef FIXED_SOFTMAX_GRAD_SAT_EN
            if (r > 127) r = 127;
            if (r < -128) r = -128;
`endif
            res[8*k +: 8] = r[7:0];
        end
        return res;
    endfunction

    task automatic send_vec(input int yv[4], input int gv[4], input bit keep, output int first_cyc);
        logic [31:0] m;
        int w;
        m = model(yv, gv);
        exp_q.push_back(m[15:0]);
        exp_q.push_back(m[31:16]);
        first_cyc = -1;
        for (int b = 0; b < 2; b++) begin
            y_in[0] = 8'(yv[2*b]);
            y_in[1] = 8'(yv[2*b+1]);
            g_in[0] = 8'(gv[2*b]);
            g_in[1] = 8'(gv[2*b+1]);
            data_in_valid = 1'b1;
            w = 0;
            while (!data_in_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL send_timeout: data_in_ready got %b required 1", data_in_ready);
            end
            if (b == 0) first_cyc = cyc;
            @(posedge clk);
            @(negedge clk);
        end
        if (!keep) data_in_valid = 1'b0;
    endtask

    task automatic recv_beat(output logic [15:0] obs, output int hs_cyc);
        int w;
        w = 0;
        while (!(data_out_valid && data_out_ready) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL recv_timeout: data_out_valid got %b required 1", data_out_valid);
        end
        obs = {data_out[1], data_out[0]};
        hs_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_in_valid = 1'b0;
        data_out_ready = 1'b0;
        y_in[0] = '0; y_in[1] = '0; g_in[0] = '0; g_in[1] = '0;
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if (data_in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_in_ready: got %b required 1", data_in_ready);
        end
        cmp_cnt++;
        if (data_out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_out_valid: got %b required 0", data_out_valid);
        end
        cmp_cnt++;
        if ({data_out[1], data_out[0]} !== 16'h0000) begin
            err_cnt++;
            $display("FAIL reset_data_out: got %h required 0000", {data_out[1], data_out[0]});
        end
        rst = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (data_in_ready !== 1'b1 || data_out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL post_reset_idle: got ready=%b valid=%b required ready=1 valid=0",
                     data_in_ready, data_out_valid);
        end
    endtask

    task automatic test_uniform();
        int yv[4];
        int gv[4];
        int c, hc;
        logic [15:0] obs, e;
        yv = '{32, 32, 32, 32};
        gv = '{16, 16, 16, 16};
        data_out_ready = 1'b1;
        send_vec(yv, gv, 1'b0, c);
        cmp_cnt++;
        if (data_out_valid !== 1'b1 || data_in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL uniform_latency: got valid=%b ready=%b required valid=1 ready=0",
                     data_out_valid, data_in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            recv_beat(obs, hc);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            cmp_cnt++;
            if (obs !== e || obs !== 16'h0000) begin
                err_cnt++;
                $display("FAIL uniform_dx beat %0d: got %h required %h", i, obs, e);
            end
        end
        cmp_cnt++;
        if (data_in_ready !== 1'b1 || data_out_valid !== 1'b0 || {data_out[1], data_out[0]} !== 16'h0000) begin
            err_cnt++;
            $display("FAIL uniform_handover: got ready=%b valid=%b data=%h required 1 0 0000",
                     data_in_ready, data_out_valid, {data_out[1], data_out[0]});
        end
    endtask

    task automatic test_opposite();
        int yv[4];
        int gv[4];
        int c, hc;
        logic [15:0] obs, e;
        yv = '{64, 64, 0, 0};
        gv = '{16, 240, 0, 0};
        data_out_ready = 1'b1;
        send_vec(yv, gv, 1'b0, c);
        for (int i = 0; i < 2; i++) begin
            recv_beat(obs, hc);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            cmp_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL opposite_dx beat %0d: got %h required %h", i, obs, e);
            end
            if (i == 0) begin
                cmp_cnt++;
                if (obs !== 16'hF808) begin
                    err_cnt++;
                    $display("FAIL opposite_dx_const: got %h required f808", obs);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int yv[4];
        int gv[4];
        int c, hc;
        logic [15:0] obs, e;
        logic [7:0] want0;
        yv = '{255, 255, 255, 255};
        gv = '{128, 127, 127, 127};
`ifdef FIXED_SOFTMAX_GRAD_SAT_EN
        want0 = 8'h80;
`else
        want0 = 8'h15;
`endif
        data_out_ready = 1'b1;
        send_vec(yv, gv, 1'b0, c);
        for (int i = 0; i < 2; i++) begin
            recv_beat(obs, hc);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            cmp_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL overflow_dx beat %0d: got %h required %h", i, obs, e);
            end
            if (i == 0) begin
                cmp_cnt++;
                if (obs[7:0] !== want0) begin
                    err_cnt++;
                    $display("FAIL overflow_dx0: got %h required %h", obs[7:0], want0);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int yv[4];
        int gv[4];
        int c, hs;
        bit pat[4];
        logic [15:0] held, obs, e;
        yv = '{64, 64, 0, 0};
        gv = '{16, 240, 0, 0};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        hs = 0;
        held = '0;
        data_out_ready = 1'b1;
        send_vec(yv, gv, 1'b0, c);
        for (int i = 0; i < 4; i++) begin
            data_out_ready = pat[i];
            obs = {data_out[1], data_out[0]};
            cmp_cnt++;
            if (data_in_ready !== 1'b0 || data_out_valid !== 1'b1) begin
                err_cnt++;
                $display("FAIL bp_emit cycle %0d: got ready=%b valid=%b required ready=0 valid=1",
                         i, data_in_ready, data_out_valid);
            end
            if (i == 1) held = obs;
            if (i >= 2) begin
                cmp_cnt++;
                if (obs !== held) begin
                    err_cnt++;
                    $display("FAIL bp_stable cycle %0d: got %h required %h", i, obs, held);
                end
            end
            if (data_out_valid && data_out_ready) begin
                hs++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                cmp_cnt++;
                if (obs !== e) begin
                    err_cnt++;
                    $display("FAIL bp_dx cycle %0d: got %h required %h", i, obs, e);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        cmp_cnt++;
        if (hs !== 2 || data_out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_beats: got beats=%0d valid=%b required beats=2 valid=0", hs, data_out_valid);
        end
        data_out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int ya[4], ga[4], yb[4], gb[4], yc[4], gc[4];
        int c0, c1, c2;
        int hc[6];
        ya = '{32, 32, 32, 32};
        ga = '{16, 16, 16, 16};
        yb = '{64, 64, 0, 0};
        gb = '{16, 240, 0, 0};
        yc = '{10, 50, 100, 20};
        gc = '{32, 224, 5, 127};
        data_out_ready = 1'b1;
        fork
            begin
                send_vec(ya, ga, 1'b1, c0);
                send_vec(yb, gb, 1'b1, c1);
                send_vec(yc, gc, 1'b0, c2);
            end
            begin
                logic [15:0] obs, e;
                for (int i = 0; i < 6; i++) begin
                    recv_beat(obs, hc[i]);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                    cmp_cnt++;
                    if (obs !== e) begin
                        err_cnt++;
                        $display("FAIL b2b_dx beat %0d: got %h required %h", i, obs, e);
                    end
                end
            end
        join
        cmp_cnt++;
        if (c1 !== hc[1] + 1 || c2 !== hc[3] + 1) begin
            err_cnt++;
            $display("FAIL b2b_handover: got accept cycles %0d,%0d required %0d,%0d",
                     c1, c2, hc[1] + 1, hc[3] + 1);
        end
        cmp_cnt++;
        if (c1 - c0 !== 4) begin
            err_cnt++;
            $display("FAIL b2b_period: got %0d cycles required 4", c1 - c0);
        end
    endtask

    task automatic test_reset_mid_emit();
        int yv[4];
        int gv[4];
        int c, hc;
        logic [15:0] obs, e;
        yv = '{64, 64, 0, 0};
        gv = '{16, 240, 0, 0};
        data_out_ready = 1'b1;
        send_vec(yv, gv, 1'b0, c);
        recv_beat(obs, hc);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        cmp_cnt++;
        if (obs !== e) begin
            err_cnt++;
            $display("FAIL rst_mid_first: got %h required %h", obs, e);
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        cmp_cnt++;
        if (data_in_ready !== 1'b1 || data_out_valid !== 1'b0 || {data_out[1], data_out[0]} !== 16'h0000) begin
            err_cnt++;
            $display("FAIL rst_mid_state: got ready=%b valid=%b data=%h required 1 0 0000",
                     data_in_ready, data_out_valid, {data_out[1], data_out[0]});
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if (data_out_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL rst_mid_stale cycle %0d: got valid=%b required 0", i, data_out_valid);
            end
        end
        yv = '{32, 32, 32, 32};
        gv = '{16, 16, 16, 16};
        send_vec(yv, gv, 1'b0, c);
        for (int i = 0; i < 2; i++) begin
            recv_beat(obs, hc);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            cmp_cnt++;
            if (obs !== e || obs !== 16'h0000) begin
                err_cnt++;
                $display("FAIL rst_mid_uniform beat %0d: got %h required %h", i, obs, e);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_uniform();
        test_opposite();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_emit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fixed_softmax_grad.md
# fixed_softmax_grad

Backward-pass companion to the fixed-point softmax activation in `activations/rtl`. It consumes the softmax forward output `y` and the upstream gradient `g` for one vector, streamed in blocks. It produces the input gradient `dx_i = y_i * (g_i - sum_j y_j*g_j)` in the same block order. The block sits between the autograd gradient stream and the preceding layer's backward datapath, and uses the same valid/ready block streaming as the forward softmax.

## Interface
- `Y_WIDTH`, 8: width of `y`. `y` is unsigned.
- `Y_FRAC`, 7: fractional bits of `y`.
- `G_WIDTH`, 8: width of `g`. `g` is two's complement.
- `G_FRAC`, 4: fractional bits of `g`.
- `OUT_WIDTH`, 8: width of `dx`. `dx` is two's complement.
- `OUT_FRAC`, 4: fractional bits of `dx`. Must satisfy `OUT_FRAC <= 2*Y_FRAC+G_FRAC`.
- `TENSOR_SIZE`, 4: vector length.
- `PARALLELISM`, 2: elements per beat. Must divide `TENSOR_SIZE`.
- `DEPTH`, `TENSOR_SIZE/PARALLELISM`: beats per vector.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `y_in[PARALLELISM]` in `Y_WIDTH`: softmax outputs.
- `g_in[PARALLELISM]` in `G_WIDTH`: upstream gradients. Shares its beat with `y_in`.
- `data_in_valid` in 1: `y_in`/`g_in` beat valid.
- `data_in_ready` out 1: beat accepted when valid and ready are both high.
- `data_out[PARALLELISM]` out `OUT_WIDTH`: `dx` beat.
- `data_out_valid` out 1: output beat valid.
- `data_out_ready` in 1: downstream accept.

## Operation
- Two states: ACCUM and EMIT. Reset enters ACCUM.
- **Storage:** an internal buffer of `DEPTH` entries, each holding `PARALLELISM` `y` values and `PARALLELISM` `g` values. It is written by the write counter `wcnt` and read by the read counter `rcnt`.
- **ACCUM:**
  - `data_in_ready=1`.
  - Each accepted beat is stored at `wcnt`.
  - `acc += sum_k y_k*g_k` for that beat.
  - Each product is signed, `Y_WIDTH+G_WIDTH+1` bits wide, with `Y_FRAC+G_FRAC` fractional bits.
  - `acc` width is the product width plus `clog2(TENSOR_SIZE)`. It never overflows.
  - When the accepted beat has `wcnt==DEPTH-1`: `wcnt` goes to 0, `acc` is latched into `s`, `acc` clears, and the state moves to EMIT.
- **EMIT:**
  - `data_in_ready=0` and `data_out_valid=1`.
  - For each lane, `dx` is computed combinationally from buffer entry `rcnt` and `s`:
    - `diff = (g << Y_FRAC) - s`, signed, `acc` width + 1.
    - `full = y * diff`, with `2*Y_FRAC+G_FRAC` fractional bits.
    - Round half up: add `1 << (SH-1)` where `SH = 2*Y_FRAC+G_FRAC-OUT_FRAC`. Then arithmetic right shift by `SH`. When `SH=0`, there is no rounding.
    - Narrow to `OUT_WIDTH`. The narrowing rule is set under Configuration.
  - On each output handshake `rcnt` increments.
  - On the handshake at `rcnt==DEPTH-1`: `rcnt` goes to 0 and the state returns to ACCUM.
- **Output gating:** `data_out` drives all-zero whenever `data_out_valid=0`.
- **Single-buffered:** the next vector is not accepted until the current vector has fully drained.
- **Reset mid-operation:** behaviour is the same in any state. State goes to ACCUM, `wcnt`, `rcnt`, `acc` and `s` clear, and any partial vector is discarded.

## Timing
- **Reset values:** `data_in_ready=1` and `data_out_valid=0` in the cycle after `rst` is sampled, and held while `rst` stays high. `data_out` is 0.
- **Latency:** the last input beat is accepted at edge t. From t+1, EMIT is active with `data_out_valid=1` and beat 0 presented.
- **Throughput:**
  - Input: one beat per cycle in ACCUM.
  - Output: one beat per cycle while `data_out_ready=1`.
  - Steady state: `2*DEPTH` cycles per vector.
- **Handshake rules:**
  - `data_out` and `data_out_valid` hold stable while stalled (`valid=1`, `ready=0`).
  - `data_in_ready` does not depend combinationally on `data_in_valid`.
  - `data_out_valid` does not depend on `data_out_ready`.
- **Handover:** the cycle after the final output handshake has `data_in_ready=1` and `data_out_valid=0`.
- **`DEPTH=1`:** each vector alternates one ACCUM cycle and one EMIT beat.

## Configuration
- `FIXED_SOFTMAX_GRAD_SAT_EN`:
  - Defined: a rounded value outside `[-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]` clamps to the nearest bound.
  - Undefined: the low `OUT_WIDTH` bits are kept (wrap).
  - In-range results are identical in both builds.

## Test plan
All scenarios use the default parameters. Values are raw codes.

- **Uniform `y`:** `y=[32,32,32,32]`, `g=[16,16,16,16]` -> `s=1.0`, `dx=[0,0,0,0]`, first output valid the cycle after the 2nd input beat.
- **Opposite gradients:** `y=[64,64,0,0]`, `g=[16,0xF0,0,0]` -> `dx=[0x08,0xF8,0x00,0x00]`.
- **Overflow:** `y=[255,255,255,255]`, `g=[0x80,127,127,127]`.
  - With the macro: `dx[0]=0x80`, `dx[1..3]=0x80`.
  - Without it: `dx[0]=0x15` (rounded -1259 wrapped).
- **Backpressure:** as the opposite-gradients scenario, with `data_out_ready` toggled 1,0,0,1 -> `data_out` stable across the stalls, exactly 2 output beats, `data_in_ready=0` throughout EMIT.
- **Back-to-back vectors:** three vectors with `data_in_valid` held high -> each vector's `dx` is correct, `s` does not leak between vectors, input accepted the cycle after the final output of the previous vector.
- **Reset mid-EMIT:** assert `rst` after the first output beat, then send the uniform-`y` vector -> outputs match the uniform-`y` scenario, and no stale beat appears.
